// File: rtl/filter_bank_scheduler_if.sv
// Bundles the sample, configuration and result signals of the filter bank scheduler.
// Latency: none; this is wiring only.
// Backpressure: none; the scheduler drops strobes that arrive while a frame is running.
interface filter_bank_scheduler_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int SIGNAL_WIDTH = 16
);
    logic                                 audio_clk_en;
    logic [NUM_CHANNELS*SIGNAL_WIDTH-1:0] in_flat;
    logic                                 cfg_we;
    logic [3:0]                           cfg_chan;
    logic [15:0]                          cfg_coef;
    logic                                 cfg_hp;
    logic [NUM_CHANNELS*SIGNAL_WIDTH-1:0] out_flat;
    logic                                 out_valid;
    logic                                 busy;
    logic                                 overrun;

    modport master (
        output audio_clk_en, in_flat, cfg_we, cfg_chan, cfg_coef, cfg_hp,
        input  out_flat, out_valid, busy, overrun
    );

    modport slave (
        input  audio_clk_en, in_flat, cfg_we, cfg_chan, cfg_coef, cfg_hp,
        output out_flat, out_valid, busy, overrun
    );
endinterface

// File: rtl/filter_bank_scheduler.sv
// Time-multiplexed single-pole RC filter engine: one shared multiplier serves all LP/HP channels.
// Latency: NUM_CHANNELS*(MUL_LATENCY+2)+2 cycles from accepted audio_clk_en to the out_valid pulse.
// Backpressure: none; audio_clk_en while busy is dropped and sets sticky overrun (FILTER_SCHED_OVERRUN_COUNT_EN adds overrun_count).
module filter_bank_scheduler #(
    parameter int NUM_CHANNELS = 4,
    parameter int SIGNAL_WIDTH = 16,
    parameter int MUL_LATENCY  = 2,
    parameter int CLOCK_RATE   = 1000000,
    parameter int SAMPLE_RATE  = 48000
) (
    input  logic clk,
    input  logic I_RSTn,
`ifdef FILTER_SCHED_OVERRUN_COUNT_EN
    output logic [7:0] overrun_count,
`endif
    filter_bank_scheduler_if.slave bus
);
    localparam int W         = SIGNAL_WIDTH;
    localparam int CW        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int FRAME_LAT = NUM_CHANNELS * (MUL_LATENCY + 2) + 2;
    localparam logic signed [W+2:0] SMAX = (W+3)'((1 << (W-1)) - 1);
    localparam logic signed [W+2:0] SMIN = ~SMAX;

    // A frame that cannot finish before the next sample strobe is a configuration error.
    if (FRAME_LAT >= CLOCK_RATE / SAMPLE_RATE) begin : g_lat_chk
        $fatal(1, "filter_bank_scheduler: frame latency exceeds the sample period");
    end
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 || MUL_LATENCY < 1 || MUL_LATENCY > 4) begin : g_par_chk
        $fatal(1, "filter_bank_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         chan_q, chan_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  ovr_q, ovr_d;
    logic                  valid_q, valid_d;
    logic signed [W-1:0]   x_q [NUM_CHANNELS], x_d [NUM_CHANNELS];
    logic signed [W-1:0]   s_q [NUM_CHANNELS], s_d [NUM_CHANNELS];
    logic signed [W-1:0]   pend_q [NUM_CHANNELS], pend_d [NUM_CHANNELS];
    logic signed [W-1:0]   out_q [NUM_CHANNELS], out_d [NUM_CHANNELS];
    logic [15:0]           ksh_q [NUM_CHANNELS], ksh_d [NUM_CHANNELS];
    logic [15:0]           k_q [NUM_CHANNELS], k_d [NUM_CHANNELS];
    logic                  hsh_q [NUM_CHANNELS], hsh_d [NUM_CHANNELS];
    logic                  hp_q [NUM_CHANNELS], hp_d [NUM_CHANNELS];
    logic signed [W:0]     diff_q, diff_d;
    logic signed [16:0]    kop_q, kop_d;
    logic signed [W+1:0]   mul_q [MUL_LATENCY], mul_d [MUL_LATENCY];
    logic [7:0]            ovc_q, ovc_d;

    logic signed [W+17:0]  prod_full;
    logic                  unused_prod_lsb;
    logic signed [W+1:0]   prod_sh;
    logic signed [W+2:0]   acc_sum;
    logic signed [W-1:0]   s_new;
    logic signed [W:0]     hp_diff;
    logic signed [W-1:0]   ch_result;

    function automatic logic signed [W-1:0] sat(input logic signed [W+2:0] v);
        if (v > SMAX)      return SMAX[W-1:0];
        else if (v < SMIN) return SMIN[W-1:0];
        else               return v[W-1:0];
    endfunction

    // Shared multiplier: operands registered in LOAD, MUL_LATENCY stages carry the floor(product/65536) part.
    assign prod_full       = diff_q * kop_q;
    assign unused_prod_lsb = ^prod_full[15:0];
    assign prod_sh         = mul_q[MUL_LATENCY-1];

    // Per-channel update for the channel currently in ACC.
    always_comb begin
        acc_sum   = {{3{s_q[chan_q][W-1]}}, s_q[chan_q]} + {prod_sh[W+1], prod_sh};
        s_new     = sat(acc_sum);
        hp_diff   = {x_q[chan_q][W-1], x_q[chan_q]} - {s_new[W-1], s_new};
        ch_result = hp_q[chan_q] ? sat({{2{hp_diff[W]}}, hp_diff}) : s_new;
    end

    // Next-state logic: configuration shadow, frame sequencing and result publication.
    always_comb begin
        state_d = state_q;  chan_d = chan_q;  cnt_d = cnt_q;
        busy_d  = busy_q;   ovr_d  = ovr_q;   valid_d = 1'b0;
        x_d = x_q;  s_d = s_q;  pend_d = pend_q;  out_d = out_q;
        ksh_d = ksh_q;  k_d = k_q;  hsh_d = hsh_q;  hp_d = hp_q;
        diff_d = diff_q;  kop_d = kop_q;  ovc_d = ovc_q;
        mul_d[0] = prod_full[W+17:16];
        for (int i = 1; i < MUL_LATENCY; i++) mul_d[i] = mul_q[i-1];

        if (bus.cfg_we && ({1'b0, bus.cfg_chan} < 5'(NUM_CHANNELS))) begin
            ksh_d[bus.cfg_chan[CW-1:0]] = bus.cfg_coef;
            hsh_d[bus.cfg_chan[CW-1:0]] = bus.cfg_hp;
        end

        if (bus.audio_clk_en && busy_q) begin
            ovr_d = 1'b1;
            if (ovc_q != 8'hFF) ovc_d = ovc_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.audio_clk_en) begin
                    for (int c = 0; c < NUM_CHANNELS; c++) x_d[c] = bus.in_flat[c*W +: W];
                    k_d     = ksh_d;
                    hp_d    = hsh_d;
                    chan_d  = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                diff_d  = {x_q[chan_q][W-1], x_q[chan_q]} - {s_q[chan_q][W-1], s_q[chan_q]};
                kop_d   = {1'b0, k_q[chan_q]};
                cnt_d   = '0;
                state_d = MUL;
            end
            MUL: begin
                if (cnt_q == 2'(MUL_LATENCY - 1)) state_d = ACC;
                else                              cnt_d   = cnt_q + 2'd1;
            end
            ACC: begin
                s_d[chan_q]    = s_new;
                pend_d[chan_q] = ch_result;
                if (chan_q == CW'(NUM_CHANNELS - 1)) begin
                    state_d = DONE;
                end else begin
                    chan_d  = chan_q + 1'b1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                out_d   = pend_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any frame in flight without a valid pulse.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q <= IDLE;  chan_q <= '0;  cnt_q <= '0;
            busy_q  <= 1'b0;  ovr_q  <= 1'b0;  valid_q <= 1'b0;
            diff_q  <= '0;    kop_q  <= '0;    ovc_q   <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                x_q[c] <= '0;  s_q[c] <= '0;  pend_q[c] <= '0;  out_q[c] <= '0;
                ksh_q[c] <= '0;  k_q[c] <= '0;  hsh_q[c] <= 1'b0;  hp_q[c] <= 1'b0;
            end
            for (int i = 0; i < MUL_LATENCY; i++) mul_q[i] <= '0;
        end else begin
            state_q <= state_d;  chan_q <= chan_d;  cnt_q <= cnt_d;
            busy_q  <= busy_d;   ovr_q  <= ovr_d;   valid_q <= valid_d;
            diff_q  <= diff_d;   kop_q  <= kop_d;   ovc_q   <= ovc_d;
            x_q <= x_d;  s_q <= s_d;  pend_q <= pend_d;  out_q <= out_d;
            ksh_q <= ksh_d;  k_q <= k_d;  hsh_q <= hsh_d;  hp_q <= hp_d;
            mul_q <= mul_d;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
        assign bus.out_flat[g*W +: W] = out_q[g];
    end
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = ovr_q;
`ifdef FILTER_SCHED_OVERRUN_COUNT_EN
    assign overrun_count = ovc_q;
`endif
endmodule
